float_to_fixed_converter: RTL and testbench

Pipelined IEEE-754 single-precision to signed fixed-point converter on the input side of the inverse-kinematics datapath. Takes float operands written by the processor over AXI and produces the Q-format words consumed by the fixed-point kinematics core. It is the mirror of the fixed-to-float output stage and uses the same fixed-point format parameters. It adds round-to-nearest, saturation and exception flags.

---
 rtl/float_to_fixed_converter.sv | 187 ++++++++++++++++++
 tb/tb_float_to_fixed_converter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_fixed_converter.sv
// IEEE-754 single-precision to signed Q-format converter, two-stage pipeline.
// Rounds to nearest (ties away from zero), saturates, and reports overflow/underflow/NaN-Inf.
module float_to_fixed_converter #(
  parameter int C_FLP_WIDTH = 32,
  parameter int C_FXP_WIDTH = 16,
  parameter int C_FXP_POINT = 12
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   TRIGGER,
  input  logic [C_FLP_WIDTH-1:0] FLP_NUM,
  input  logic                   CLR_FLAGS,
  output logic [C_FXP_WIDTH-1:0] FXP_NUM,
  output logic                   VALID,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW,
  output logic                   NAN_INF,
  output logic                   STICKY_ERR
);

  localparam int MW   = C_FXP_WIDTH + 1;
  localparam int WIDE = 24 + C_FXP_WIDTH + 2;

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_DENORM = 3'd1;
  localparam logic [2:0] CLS_NORMAL = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_NAN    = 3'd4;

  localparam logic [C_FXP_WIDTH-1:0] FXP_MAX = {1'b0, {(C_FXP_WIDTH-1){1'b1}}};
  localparam logic [C_FXP_WIDTH-1:0] FXP_MIN = {1'b1, {(C_FXP_WIDTH-1){1'b0}}};
  localparam logic [MW:0]            POS_LIMIT = {2'b00, FXP_MAX};
  localparam logic [MW:0]            NEG_LIMIT = {2'b00, FXP_MIN};

  logic               sign_s;
  logic [7:0]         exp_s;
  logic [22:0]        man_s;
  logic [23:0]        sig_s;
  logic signed [11:0] shift_s;
  logic [11:0]        rsh_s;
  logic [WIDE-1:0]    wide_s;

  logic [2:0]         cls_d,  cls1_q;
  logic [MW-1:0]      mag_d,  mag1_q;
  logic               rnd_d,  rnd1_q;
  logic               sign1_q, v1_q;

  logic [MW:0]              sum_s;
  logic [C_FXP_WIDTH-1:0]   fxp_d, fxp_q;
  logic                     of_d, uf_d, ni_d, sticky_d;
  logic                     of_q, uf_q, ni_q, valid_q, sticky_q;

  assign sign_s  = FLP_NUM[31];
  assign exp_s   = FLP_NUM[30:23];
  assign man_s   = FLP_NUM[22:0];
  assign sig_s   = {1'b1, man_s};
  assign shift_s = $signed({4'b0000, exp_s}) + $signed(12'(C_FXP_POINT)) - 12'sd150;
  assign rsh_s   = 12'd0 - shift_s;

  // Stage 1: classify and align the significand; magnitude clamps to all-ones when out of range.
  always_comb begin
    cls_d  = CLS_NORMAL;
    mag_d  = '0;
    rnd_d  = 1'b0;
    wide_s = '0;
    if (exp_s == 8'd0) begin
      cls_d = (man_s == 23'd0) ? CLS_ZERO : CLS_DENORM;
    end else if (exp_s == 8'hFF) begin
      cls_d = (man_s == 23'd0) ? CLS_INF : CLS_NAN;
    end else if (!shift_s[11]) begin
      if (shift_s > $signed(12'(C_FXP_WIDTH))) begin
        mag_d = '1;
      end else begin
        wide_s = {{(WIDE-24){1'b0}}, sig_s} << shift_s[5:0];
        mag_d  = (|wide_s[WIDE-1:MW]) ? '1 : wide_s[MW-1:0];
      end
    end else if (rsh_s > 12'd24) begin
      mag_d = '0;
      rnd_d = 1'b0;
    end else begin
      wide_s = {{(WIDE-24){1'b0}}, sig_s} >> rsh_s[4:0];
      mag_d  = (|wide_s[WIDE-1:MW]) ? '1 : wide_s[MW-1:0];
      rnd_d  = |(sig_s & (24'd1 << (rsh_s[4:0] - 5'd1)));
    end
  end

  // Stage 1 registers; data only moves on a valid sample.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      cls1_q  <= CLS_ZERO;
      mag1_q  <= '0;
      rnd1_q  <= 1'b0;
    end else begin
      v1_q <= TRIGGER;
      if (TRIGGER) begin
        sign1_q <= sign_s;
        cls1_q  <= cls_d;
        mag1_q  <= mag_d;
        rnd1_q  <= rnd_d;
      end
    end
  end

  assign sum_s = {1'b0, mag1_q} + {{MW{1'b0}}, rnd1_q};

  // Stage 2: round, saturate, negate and derive per-sample flags.
  always_comb begin
    fxp_d = '0;
    of_d  = 1'b0;
    uf_d  = 1'b0;
    ni_d  = 1'b0;
    case (cls1_q)
      CLS_ZERO: begin
        fxp_d = '0;
      end
      CLS_DENORM: begin
        uf_d = 1'b1;
      end
      CLS_INF: begin
        fxp_d = sign1_q ? FXP_MIN : FXP_MAX;
        of_d  = 1'b1;
        ni_d  = 1'b1;
      end
      CLS_NAN: begin
        ni_d = 1'b1;
      end
      CLS_NORMAL: begin
        if (sum_s == '0) begin
          uf_d = 1'b1;
        end else if (!sign1_q && (sum_s > POS_LIMIT)) begin
          fxp_d = FXP_MAX;
          of_d  = 1'b1;
        end else if (sign1_q && (sum_s > NEG_LIMIT)) begin
          fxp_d = FXP_MIN;
          of_d  = 1'b1;
        end else begin
          fxp_d = sign1_q ? -sum_s[C_FXP_WIDTH-1:0] : sum_s[C_FXP_WIDTH-1:0];
        end
      end
      default: begin
        fxp_d = '0;
      end
    endcase
  end

  // Sticky error: a flagged sample entering or sitting on the outputs overrides a clear.
  always_comb begin
    if ((v1_q && (of_d || uf_d || ni_d)) || (valid_q && (of_q || uf_q || ni_q))) begin
      sticky_d = 1'b1;
    end else if (CLR_FLAGS) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Output registers hold the last result between valid pulses.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q  <= 1'b0;
      fxp_q    <= '0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
      ni_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= v1_q;
      sticky_q <= sticky_d;
      if (v1_q) begin
        fxp_q <= fxp_d;
        of_q  <= of_d;
        uf_q  <= uf_d;
        ni_q  <= ni_d;
      end
    end
  end

  assign FXP_NUM    = fxp_q;
  assign VALID      = valid_q;
  assign OVERFLOW   = of_q;
  assign UNDERFLOW  = uf_q;
  assign NAN_INF    = ni_q;
  assign STICKY_ERR = sticky_q;

endmodule

// File: tb/tb_float_to_fixed_converter.sv
// Directed self-checking bench for float_to_fixed_converter (W=16, Q4.12).
module tb_float_to_fixed_converter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        TRIGGER = 1'b0;
  logic [31:0] FLP_NUM = 32'h0;
  logic        CLR_FLAGS = 1'b0;
  logic [15:0] FXP_NUM;
  logic        VALID, OVERFLOW, UNDERFLOW, NAN_INF, STICKY_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  float_to_fixed_converter #(
    .C_FLP_WIDTH(32),
    .C_FXP_WIDTH(16),
    .C_FXP_POINT(12)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .TRIGGER   (TRIGGER),
    .FLP_NUM   (FLP_NUM),
    .CLR_FLAGS (CLR_FLAGS),
    .FXP_NUM   (FXP_NUM),
    .VALID     (VALID),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
    .NAN_INF   (NAN_INF),
    .STICKY_ERR(STICKY_ERR)
  );

  // Drives one trigger; returns VALID one cycle later and {VALID,FXP,OF,UF,NI} two cycles later.
  task automatic convert_one(input logic [31:0] f, output logic v_early,
                             output logic [19:0] obs, output logic st);
    @(negedge CLK);
    TRIGGER = 1'b1;
    FLP_NUM = f;
    @(negedge CLK);
    TRIGGER = 1'b0;
    FLP_NUM = 32'h0;
    v_early = VALID;
    @(negedge CLK);
    obs = {VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF};
    st  = STICKY_ERR;
  endtask

  task automatic pulse_clear();
    @(negedge CLK);
    CLR_FLAGS = 1'b1;
    @(negedge CLK);
    CLR_FLAGS = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    TRIGGER = 1'b1;
    FLP_NUM = 32'h3F800000;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF, STICKY_ERR} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 000000",
               {VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF, STICKY_ERR});
    end
    nRST = 1'b1;
    TRIGGER = 1'b0;
    FLP_NUM = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++;
      if (VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_trigger_ignored[%0d]: VALID got %b expected 0", i, VALID);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] vin [3];
    logic [19:0] vexp [3];
    logic        ve, st;
    logic [19:0] obs;
    vin  = '{32'h3F800000, 32'hBFC00000, 32'h00000000};
    vexp = '{{1'b1, 16'h1000, 3'b000}, {1'b1, 16'hE800, 3'b000}, {1'b1, 16'h0000, 3'b000}};
    for (int i = 0; i < 3; i++) begin
      convert_one(vin[i], ve, obs, st);
      n_checks += 3;
      if (ve !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: early VALID got %b expected 0", i, ve);
      end
      if (obs !== vexp[i]) begin
        n_fail++;
        $display("FAIL basic[%0d]: got %h expected %h", i, obs, vexp[i]);
      end
      if (st !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_sticky[%0d]: got %b expected 0", i, st);
      end
    end
  endtask

  task automatic test_limits();
    logic [31:0] vin [9];
    logic [19:0] vexp [9];
    logic        ve, st;
    logic [19:0] obs;
    vin  = '{32'h41000000, 32'hC1000000, 32'hFF800000, 32'h7F800000, 32'h7FC00000,
             32'h80000000, 32'h40FFFFFF, 32'hC0FFFFFF, 32'hC1000800};
    vexp = '{{1'b1, 16'h7FFF, 3'b100}, {1'b1, 16'h8000, 3'b000}, {1'b1, 16'h8000, 3'b101},
             {1'b1, 16'h7FFF, 3'b101}, {1'b1, 16'h0000, 3'b001}, {1'b1, 16'h0000, 3'b000},
             {1'b1, 16'h7FFF, 3'b100}, {1'b1, 16'h8000, 3'b000}, {1'b1, 16'h8000, 3'b100}};
    for (int i = 0; i < 9; i++) begin
      convert_one(vin[i], ve, obs, st);
      n_checks += 2;
      if (obs !== vexp[i]) begin
        n_fail++;
        $display("FAIL limits[%0d]: got %h expected %h", i, obs, vexp[i]);
      end
      if (st !== 1'b1) begin
        n_fail++;
        $display("FAIL limits_sticky[%0d]: got %b expected 1", i, st);
      end
    end
  endtask

  task automatic test_round();
    logic [31:0] vin [7];
    logic [19:0] vexp [7];
    logic        vst [7];
    logic        ve, st;
    logic [19:0] obs;
    pulse_clear();
    n_checks++;
    if (STICKY_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL round_pre_clear: sticky got %b expected 0", STICKY_ERR);
    end
    vin  = '{32'h39000000, 32'hB9000000, 32'h39C00000, 32'hB9C00000,
             32'h38800000, 32'h00000001, 32'h80000001};
    vexp = '{{1'b1, 16'h0001, 3'b000}, {1'b1, 16'hFFFF, 3'b000}, {1'b1, 16'h0002, 3'b000},
             {1'b1, 16'hFFFE, 3'b000}, {1'b1, 16'h0000, 3'b010}, {1'b1, 16'h0000, 3'b010},
             {1'b1, 16'h0000, 3'b010}};
    vst  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      convert_one(vin[i], ve, obs, st);
      n_checks += 2;
      if (obs !== vexp[i]) begin
        n_fail++;
        $display("FAIL round[%0d]: got %h expected %h", i, obs, vexp[i]);
      end
      if (st !== vst[i]) begin
        n_fail++;
        $display("FAIL round_sticky[%0d]: got %b expected %b", i, st, vst[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [8];
    logic [18:0] vexp [8];
    logic [13:0] pat [2];
    logic [18:0] last;
    logic        have_last;
    int          sent, recv;
    vin  = '{32'h3F800000, 32'hBFC00000, 32'h41000000, 32'h39000000,
             32'h00000000, 32'hC1000000, 32'h7FC00000, 32'h3E800000};
    vexp = '{{16'h1000, 3'b000}, {16'hE800, 3'b000}, {16'h7FFF, 3'b100}, {16'h0001, 3'b000},
             {16'h0000, 3'b000}, {16'h8000, 3'b000}, {16'h0000, 3'b001}, {16'h0400, 3'b000}};
    pat  = '{14'b00000011111111, 14'b00001111100111};
    have_last = 1'b0;
    last = '0;
    for (int p = 0; p < 2; p++) begin
      sent = 0;
      recv = 0;
      for (int j = 0; j < 16; j++) begin
        @(negedge CLK);
        n_checks++;
        if (j >= 2 && pat[p][j-2]) begin
          if ({VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF} !== {1'b1, vexp[recv]}) begin
            n_fail++;
            $display("FAIL stream[%0d][%0d]: got %h expected %h", p, j,
                     {VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF}, {1'b1, vexp[recv]});
          end
          last = vexp[recv];
          have_last = 1'b1;
          recv++;
        end else if (have_last) begin
          if ({VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF} !== {1'b0, last}) begin
            n_fail++;
            $display("FAIL stream_hold[%0d][%0d]: got %h expected %h", p, j,
                     {VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF}, {1'b0, last});
          end
        end else begin
          if (VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_idle[%0d][%0d]: VALID got %b expected 0", p, j, VALID);
          end
        end
        if (j < 14 && pat[p][j]) begin
          TRIGGER = 1'b1;
          FLP_NUM = vin[sent];
          sent++;
        end else begin
          TRIGGER = 1'b0;
          FLP_NUM = 32'h0;
        end
      end
      n_checks++;
      if (recv !== 8) begin
        n_fail++;
        $display("FAIL stream_count[%0d]: got %0d expected 8", p, recv);
      end
    end
  endtask

  task automatic test_sticky();
    logic        ve, st;
    logic [19:0] obs;
    pulse_clear();
    n_checks++;
    if (STICKY_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear0: got %b expected 0", STICKY_ERR);
    end
    convert_one(32'h3F800000, ve, obs, st);
    n_checks++;
    if (st !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clean_sample: got %b expected 0", st);
    end
    convert_one(32'h41000000, ve, obs, st);
    n_checks++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set: got %b expected 1", st);
    end
    pulse_clear();
    n_checks++;
    if (STICKY_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear: got %b expected 0", STICKY_ERR);
    end
    // Clear asserted while the overflowing result is on the outputs.
    convert_one(32'h41000000, ve, obs, st);
    CLR_FLAGS = 1'b1;
    @(negedge CLK);
    CLR_FLAGS = 1'b0;
    n_checks++;
    if (STICKY_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins_valid: got %b expected 1", STICKY_ERR);
    end
    pulse_clear();
    // Clear asserted in the cycle the overflowing result is being registered.
    @(negedge CLK);
    TRIGGER = 1'b1;
    FLP_NUM = 32'hC2000000;
    @(negedge CLK);
    TRIGGER = 1'b0;
    CLR_FLAGS = 1'b1;
    @(negedge CLK);
    CLR_FLAGS = 1'b0;
    n_checks++;
    if ({VALID, FXP_NUM, OVERFLOW, STICKY_ERR} !== {1'b1, 16'h8000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sticky_set_wins_stage2: got %h expected %h",
               {VALID, FXP_NUM, OVERFLOW, STICKY_ERR}, {1'b1, 16'h8000, 1'b1, 1'b1});
    end
  endtask

  task automatic test_reset_midflight();
    logic        ve, st;
    logic [19:0] obs;
    convert_one(32'h41000000, ve, obs, st);
    @(negedge CLK);
    TRIGGER = 1'b1;
    FLP_NUM = 32'h3F800000;
    @(negedge CLK);
    TRIGGER = 1'b0;
    FLP_NUM = 32'h0;
    nRST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF, STICKY_ERR} !== 21'h0) begin
      n_fail++;
      $display("FAIL midflight_reset: got %h expected 000000",
               {VALID, FXP_NUM, OVERFLOW, UNDERFLOW, NAN_INF, STICKY_ERR});
    end
    nRST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_no_valid: got %b expected 0", VALID);
    end
    convert_one(32'h3F800000, ve, obs, st);
    n_checks++;
    if ({ve, obs, st} !== {1'b0, 1'b1, 16'h1000, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL midflight_resume: got %h expected %h",
               {ve, obs, st}, {1'b0, 1'b1, 16'h1000, 3'b000, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_round();
    test_back_to_back();
    test_sticky();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
